// File: rtl/dmem_wb_responder_if.sv
// Wishbone B4 classic bundle for the data-memory responder.
// Signal names follow the slave's view of the bus.
interface dmem_wb_responder_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        busy_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i,
    output wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  busy_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i,
    input  wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output busy_o
  );
endinterface

// File: rtl/dmem_wb_responder.sv
// Wishbone classic data-memory responder: byte-lane SRAM,
// programmable wait states, error termination out of range.
module dmem_wb_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                 clk,
  input logic                 reset,
  dmem_wb_responder_if.slave  bus
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic           r_we;
  logic [AW-1:0]  r_idx;
  logic [3:0]     r_sel;
  logic [31:0]    r_dat;
  logic           r_inr;
  logic           r_ack;
  logic           r_err;
  logic           r_busy;
  logic [31:0]    r_rdat;
  logic [31:0]    r_mem [DEPTH_WORDS];

  logic           w_req;
  logic [31:0]    w_off;
  logic [31:0]    w_idx;
  logic           w_inr;
  logic           w_enter_resp;
  logic           w_cur_we;
  logic           w_cur_inr;
  logic [AW-1:0]  w_cur_idx;
  logic [3:0]     w_cur_sel;
  logic [31:0]    w_cur_dat;

  assign w_req = bus.wb_cyc_i & bus.wb_stb_i;
  assign w_off = bus.wb_adr_i - BASE_ADDR;
  assign w_idx = w_off >> 2;
  assign w_inr = (bus.wb_adr_i >= BASE_ADDR) &&
                 (w_idx < 32'(DEPTH_WORDS));

  // With no wait states the response edge is the capture edge,
  // so the live bus fields stand in for the captured copy.
  always_comb begin
    w_cur_we  = r_we;
    w_cur_inr = r_inr;
    w_cur_idx = r_idx;
    w_cur_sel = r_sel;
    w_cur_dat = r_dat;
    if (r_state == S_IDLE) begin
      w_cur_we  = bus.wb_we_i;
      w_cur_inr = w_inr;
      w_cur_idx = w_idx[AW-1:0];
      w_cur_sel = bus.wb_sel_i;
      w_cur_dat = bus.wb_dat_i;
    end
  end

  always_comb begin
    w_enter_resp = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        (r_state == S_IDLE):
          w_enter_resp = w_req && (WAIT_STATES == 0);
        (r_state == S_WAIT):
          w_enter_resp = bus.wb_cyc_i && (r_cnt == 4'd0);
        default:
          w_enter_resp = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter_resp && w_cur_inr && w_cur_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_cur_sel[k])
          r_mem[w_cur_idx][8*k +: 8] <= w_cur_dat[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_sel   <= 4'd0;
      r_dat   <= 32'd0;
      r_inr   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdat  <= 32'd0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we   <= bus.wb_we_i;
            r_idx  <= w_idx[AW-1:0];
            r_sel  <= bus.wb_sel_i;
            r_dat  <= bus.wb_dat_i;
            r_inr  <= w_inr;
            r_busy <= 1'b1;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.wb_cyc_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ack   <= r_inr;
          r_err   <= ~r_inr;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_enter_resp) begin
        if (!w_cur_inr)
          r_rdat <= 32'd0;
        else if (!w_cur_we)
          r_rdat <= r_mem[w_cur_idx];
      end
    end
  end

  assign bus.wb_dat_o = r_rdat;
  assign bus.wb_ack_o = r_ack;
  assign bus.wb_err_o = r_err;
  assign bus.busy_o   = r_busy;

endmodule

// File: tb/tb_dmem_wb_responder.sv
// Scoreboard bench: three responders (0, 1 and 3 wait states)
// driven by a classic master against a word-array model.
module tb_dmem_wb_responder;

  typedef struct {
    int          d;
    bit          err;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [31:0] adr   [3];
  logic [3:0]  sel   [3];
  logic [31:0] wdat  [3];
  logic [31:0] rdat  [3];
  logic        ack   [3];
  logic        err   [3];
  logic        busy  [3];

  int          nchk;
  int          nerr;
  int          cyc_cnt;
  exp_t        sb [$];
  exp_t        me;
  bit   [31:0] mdl  [3][1024];
  logic [31:0] last [3];
  int          widx [10];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    dmem_wb_responder_if bus ();
    assign bus.wb_cyc_i = cyc[g];
    assign bus.wb_stb_i = stb[g];
    assign bus.wb_we_i  = we[g];
    assign bus.wb_adr_i = adr[g];
    assign bus.wb_sel_i = sel[g];
    assign bus.wb_dat_i = wdat[g];
    assign rdat[g] = bus.wb_dat_o;
    assign ack[g]  = bus.wb_ack_o;
    assign err[g]  = bus.wb_err_o;
    assign busy[g] = bus.busy_o;
    dmem_wb_responder #(
      .DEPTH_WORDS (1024),
      .WAIT_STATES (WS),
      .BASE_ADDR   (32'h0)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: every ack/err cycle consumes one expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ack[d] === 1'b1 || err[d] === 1'b1) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_resp dut%0d ack=%b err=%b",
                   d, ack[d], err[d]);
        end else begin
          me = sb.pop_front();
          nchk++;
          if (me.d != d || ack[d] !== !me.err ||
              err[d] !== me.err) begin
            nerr++;
            $display("FAIL resp_kind dut%0d ack=%b err=%b want dut%0d err=%b",
                     d, ack[d], err[d], me.d, me.err);
          end
          nchk++;
          if (rdat[d] !== me.dat) begin
            nerr++;
            $display("FAIL resp_data dut%0d got=%h want=%h",
                     d, rdat[d], me.dat);
          end
          nchk++;
          if (cyc_cnt != me.cyc) begin
            nerr++;
            $display("FAIL resp_latency dut%0d got=%0d want=%0d",
                     d, cyc_cnt, me.cyc);
          end
        end
      end
    end
  end

  // Called on a negedge; returns on the negedge where ack/err shows.
  task automatic xfer(input int d, input bit w,
                      input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] dt);
    exp_t e;
    int   t;
    int   ix;
    bit   inr;
    inr = (a >> 2) < 32'd1024;
    ix  = int'(a >> 2);
    e.d   = d;
    e.cyc = cyc_cnt + 2 + ws_of(d);
    e.err = !inr;
    if (!inr) begin
      last[d] = 32'd0;
    end else if (w) begin
      for (int k = 0; k < 4; k++)
        if (s[k]) mdl[d][ix][8*k +: 8] = dt[8*k +: 8];
    end else begin
      last[d] = mdl[d][ix];
    end
    e.dat = last[d];
    sb.push_back(e);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = a; sel[d] = s; wdat[d] = dt;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(ack[d] === 1'b1 || err[d] === 1'b1) && t < 40);
    if (t >= 40) begin
      nchk++;
      nerr++;
      $display("FAIL timeout dut%0d got=none want=response", d);
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    nchk = 0;
    nerr = 0;
    widx = '{0, 1, 4, 8, 9, 100, 512, 1021, 1022, 1023};
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0;
      adr[d] = 0; sel[d] = 0; wdat[d] = 0;
      last[d] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_dat%0d", d), rdat[d], 32'd0);
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 10; i++)
        xfer(d, 1'b1, 32'(widx[i]) << 2, 4'hF, $urandom);

    xfer(1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    xfer(1, 1'b0, 32'h10, 4'h0, 32'h0);
    chk("rd_full", rdat[1], 32'hDEADBEEF);
    xfer(1, 1'b1, 32'h20, 4'hF, 32'h11223344);
    xfer(1, 1'b1, 32'h20, 4'b0100, 32'h00AB0000);
    xfer(1, 1'b0, 32'h20, 4'hF, 32'h0);
    chk("rd_byte", rdat[1], 32'h11AB3344);
    xfer(1, 1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF);
    chk("wr_sel0_hold", rdat[1], 32'h11AB3344);
    xfer(1, 1'b0, 32'h20, 4'hF, 32'h0);
    chk("rd_sel0", rdat[1], 32'h11AB3344);
    xfer(1, 1'b1, 32'h22, 4'b1100, 32'hCAFE0000);
    xfer(1, 1'b0, 32'h22, 4'hF, 32'h0);
    chk("rd_half", rdat[1], 32'hCAFE3344);
    xfer(1, 1'b0, 32'h1000, 4'hF, 32'h0);
    chk("oor_dat", rdat[1], 32'h0);
    chk("oor_ack", 32'(ack[1]), 32'd0);
    xfer(1, 1'b1, 32'h1000, 4'hF, 32'h12345678);
    xfer(1, 1'b0, 32'h0, 4'hF, 32'h0);
    xfer(1, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("oor_wr_keep", rdat[1], 32'hDEADBEEF);
    xfer(0, 1'b1, 32'h40, 4'hF, 32'hA5A55A5A);
    xfer(0, 1'b0, 32'h40, 4'hF, 32'h0);
    chk("ws0_rd", rdat[0], 32'hA5A55A5A);
    xfer(2, 1'b1, 32'h40, 4'hF, 32'h0F1E2D3C);
    xfer(2, 1'b0, 32'h40, 4'hF, 32'h0);
    chk("ws3_rd", rdat[2], 32'h0F1E2D3C);

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 60; n++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if ($urandom_range(0, 9) == 0)
          a = 32'h1000 + $urandom_range(0, 4095);
        else
          a = (32'(widx[$urandom_range(0, 9)]) << 2) |
              32'($urandom_range(0, 3));
        xfer(d, 1'($urandom), a, 4'($urandom), $urandom);
      end
    end

    // Abort: cyc dropped in the second wait cycle.
    cyc[2] = 1; stb[2] = 1; we[2] = 1;
    adr[2] = 32'h10; sel[2] = 4'hF; wdat[2] = 32'hBAD0BAD0;
    @(negedge clk);
    chk("abort_busy_wait", 32'(busy[2]), 32'd1);
    @(negedge clk);
    cyc[2] = 0; stb[2] = 0;
    @(negedge clk);
    chk("abort_busy_idle", 32'(busy[2]), 32'd0);
    repeat (6) @(negedge clk);
    xfer(2, 1'b0, 32'h10, 4'hF, 32'h0);
    chk("abort_keep", rdat[2], mdl[2][4]);

    // Reset while a write waits.
    cyc[1] = 1; stb[1] = 1; we[1] = 1;
    adr[1] = 32'h20; sel[1] = 4'hF; wdat[1] = 32'h0BADF00D;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cyc[1] = 0; stb[1] = 0;
    for (int d = 0; d < 3; d++) last[d] = 32'd0;
    chk("rst_mid_busy", 32'(busy[1]), 32'd0);
    chk("rst_mid_dat", rdat[1], 32'd0);
    repeat (4) @(negedge clk);
    xfer(1, 1'b0, 32'h20, 4'hF, 32'h0);
    chk("rst_mid_keep", rdat[1], 32'hCAFE3344 & 32'h0 | mdl[1][8]);

    repeat (8) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
